// File: rtl/cond_logic_if.sv
// Bus between the multicycle control FSM (master) and the conditional-execution stage (slave).
// Optional statistics outputs appear when COND_LOGIC_STATS_EN is defined.
interface cond_logic_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic [3:0] Rd;
  logic       RegW;
  logic       MemW;
  logic       NextPC;
  logic       BranchS;
  logic       RegWrite;
  logic       MemWrite;
  logic       PCWrite;
  logic [3:0] Flags;
  logic       CondEx;
`ifdef COND_LOGIC_STATS_EN
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SquashCnt;

  modport master (
    output Cond, ALUFlags, FlagW, Rd, RegW, MemW, NextPC, BranchS,
    input  RegWrite, MemWrite, PCWrite, Flags, CondEx, ExecCnt, SquashCnt
  );
  modport slave (
    input  Cond, ALUFlags, FlagW, Rd, RegW, MemW, NextPC, BranchS,
    output RegWrite, MemWrite, PCWrite, Flags, CondEx, ExecCnt, SquashCnt
  );
`else
  modport master (
    output Cond, ALUFlags, FlagW, Rd, RegW, MemW, NextPC, BranchS,
    input  RegWrite, MemWrite, PCWrite, Flags, CondEx
  );
  modport slave (
    input  Cond, ALUFlags, FlagW, Rd, RegW, MemW, NextPC, BranchS,
    output RegWrite, MemWrite, PCWrite, Flags, CondEx
  );
`endif
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and gates FSM write strobes.
// Optional saturating exec/squash counters are enabled by defining COND_LOGIC_STATS_EN.
module cond_logic #(
  parameter bit          NV_EXECUTES = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input logic        clk,
  input logic        reset,
  cond_logic_if.slave bus
);

  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       cond_ex_c;
  logic       n_f, z_f, c_f, v_f;
  logic       pcs_c;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cond_logic: CNT_W must be at least 1");
  end

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition evaluation against the flags as they stand before this cycle's update
  always_comb begin
    cond_ex_c = 1'b0;
    unique case (bus.Cond)
      4'b0000: cond_ex_c = z_f;
      4'b0001: cond_ex_c = ~z_f;
      4'b0010: cond_ex_c = c_f;
      4'b0011: cond_ex_c = ~c_f;
      4'b0100: cond_ex_c = n_f;
      4'b0101: cond_ex_c = ~n_f;
      4'b0110: cond_ex_c = v_f;
      4'b0111: cond_ex_c = ~v_f;
      4'b1000: cond_ex_c = c_f & ~z_f;
      4'b1001: cond_ex_c = ~c_f | z_f;
      4'b1010: cond_ex_c = (n_f == v_f);
      4'b1011: cond_ex_c = (n_f != v_f);
      4'b1100: cond_ex_c = ~z_f & (n_f == v_f);
      4'b1101: cond_ex_c = z_f | (n_f != v_f);
      4'b1110: cond_ex_c = 1'b1;
      4'b1111: cond_ex_c = NV_EXECUTES;
      default: cond_ex_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      cond_ex_q <= cond_ex_c;
      if (bus.FlagW[1] && cond_ex_c) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0] && cond_ex_c) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Writes use the condition registered one cycle earlier; Fetch's NextPC is never gated
  assign pcs_c        = (bus.RegW & (bus.Rd == 4'hF)) | bus.BranchS;
  assign bus.RegWrite = bus.RegW & cond_ex_q;
  assign bus.MemWrite = bus.MemW & cond_ex_q;
  assign bus.PCWrite  = bus.NextPC | (pcs_c & cond_ex_q);
  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex_q;

`ifdef COND_LOGIC_STATS_EN
  logic [CNT_W-1:0] exec_cnt_q;
  logic [CNT_W-1:0] squash_cnt_q;

  // Saturating counters of executed versus squashed write requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else if (bus.RegW || bus.MemW || bus.BranchS) begin
      if (cond_ex_q) begin
        if (exec_cnt_q != {CNT_W{1'b1}}) exec_cnt_q <= exec_cnt_q + CNT_W'(1);
      end else begin
        if (squash_cnt_q != {CNT_W{1'b1}}) squash_cnt_q <= squash_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ExecCnt   = exec_cnt_q;
  assign bus.SquashCnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic with NV_EXECUTES=0.
// Statistics checks are compiled in when COND_LOGIC_STATS_EN is defined.
module tb_cond_logic;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cond_logic_if #(.CNT_W(16)) bus ();

  cond_logic #(.NV_EXECUTES(1'b0), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset        = 1'b0;
    bus.Cond     = 4'b1110;
    bus.ALUFlags = 4'b0000;
    bus.FlagW    = 2'b00;
    bus.Rd       = 4'h0;
    bus.RegW     = 1'b1;
    bus.MemW     = 1'b0;
    bus.NextPC   = 1'b0;
    bus.BranchS  = 1'b0;
    step();
    step();
    check("rst_flags", 16'(bus.Flags), 16'h0);
    check("rst_condex", 16'(bus.CondEx), 16'h0);
    check("rst_regwrite", 16'(bus.RegWrite), 16'h0);
    check("rst_pcwrite", 16'(bus.PCWrite), 16'h0);

    // Release reset; AL with flag write 0100
    reset = 1'b1;
    bus.RegW = 1'b0;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b0100;
    step();
    check("set_flags", 16'(bus.Flags), 16'h4);
    check("set_condex_al", 16'(bus.CondEx), 16'h1);

    // EQ sees Z=1
    bus.FlagW = 2'b00;
    bus.ALUFlags = 4'b0000;
    bus.Cond = 4'b0000;
    bus.RegW = 1'b1;
    step();
    check("eq_condex", 16'(bus.CondEx), 16'h1);
    check("eq_regwrite", 16'(bus.RegWrite), 16'h1);
    check("eq_flags_hold", 16'(bus.Flags), 16'h4);

    // NE squashes a memory write
    bus.Cond = 4'b0001;
    bus.RegW = 1'b0;
    bus.MemW = 1'b1;
    step();
    check("ne_condex", 16'(bus.CondEx), 16'h0);
    check("ne_memwrite", 16'(bus.MemWrite), 16'h0);
    check("ne_pcwrite", 16'(bus.PCWrite), 16'h0);
    bus.NextPC = 1'b1;
    #1;
    check("nextpc_ungated", 16'(bus.PCWrite), 16'h1);
    bus.NextPC = 1'b0;
    bus.MemW = 1'b0;

    // Mid-instruction asynchronous reset
    bus.Cond = 4'b1110;
    bus.RegW = 1'b1;
    step();
    check("pre_rst_regwrite", 16'(bus.RegWrite), 16'h1);
    reset = 1'b0;
    #1;
    check("async_rst_flags", 16'(bus.Flags), 16'h0);
    check("async_rst_condex", 16'(bus.CondEx), 16'h0);
    check("async_rst_regwrite", 16'(bus.RegWrite), 16'h0);
    reset = 1'b1;
    bus.RegW = 1'b0;

    // Partial flag write: C,V only
    bus.FlagW = 2'b01;
    bus.ALUFlags = 4'b1111;
    step();
    check("partial_flags", 16'(bus.Flags), 16'h3);
    bus.FlagW = 2'b00;
    step();
    check("partial_hold", 16'(bus.Flags), 16'h3);

    // Flag write with a failing condition leaves flags unchanged
    bus.Cond = 4'b0000;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b1100;
    step();
    check("squash_flagw_flags", 16'(bus.Flags), 16'h3);
    check("squash_flagw_condex", 16'(bus.CondEx), 16'h0);

    // N=1, V=0, Z=0
    bus.Cond = 4'b1110;
    bus.ALUFlags = 4'b1000;
    step();
    check("nv10_flags", 16'(bus.Flags), 16'h8);
    bus.FlagW = 2'b00;
    bus.Cond = 4'b1011;
    step();
    check("lt_true", 16'(bus.CondEx), 16'h1);
    bus.Cond = 4'b1010;
    step();
    check("ge_false", 16'(bus.CondEx), 16'h0);
    bus.Cond = 4'b1000;
    step();
    check("hi_false", 16'(bus.CondEx), 16'h0);
    bus.Cond = 4'b1001;
    step();
    check("ls_true", 16'(bus.CondEx), 16'h1);

    // N=1, V=1, Z=0
    bus.Cond = 4'b1110;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b1001;
    step();
    check("nv11_flags", 16'(bus.Flags), 16'h9);
    bus.FlagW = 2'b00;
    bus.Cond = 4'b1100;
    step();
    check("gt_true", 16'(bus.CondEx), 16'h1);
    bus.Cond = 4'b1101;
    step();
    check("le_false", 16'(bus.CondEx), 16'h0);

    // PC paths
    bus.Cond = 4'b1110;
    bus.Rd = 4'hF;
    bus.RegW = 1'b1;
    step();
    check("rd15_pcwrite", 16'(bus.PCWrite), 16'h1);
    check("rd15_regwrite", 16'(bus.RegWrite), 16'h1);
    bus.BranchS = 1'b1;
    #1;
    check("regw_branch_pcwrite", 16'(bus.PCWrite), 16'h1);
    bus.Cond = 4'b1111;
    bus.RegW = 1'b0;
    bus.Rd = 4'h0;
    step();
    check("nv_condex", 16'(bus.CondEx), 16'h0);
    check("branch_squash_pcwrite", 16'(bus.PCWrite), 16'h0);
    bus.BranchS = 1'b0;

`ifdef COND_LOGIC_STATS_EN
    // Three squashed register writes from a clean reset
    reset = 1'b0;
    bus.Cond = 4'b1111;
    bus.RegW = 1'b1;
    #1;
    check("stats_rst_squash", bus.SquashCnt, 16'h0);
    reset = 1'b1;
    step();
    step();
    step();
    check("stats_squash3", bus.SquashCnt, 16'h3);
    check("stats_exec0", bus.ExecCnt, 16'h0);
    bus.Cond = 4'b1110;
    step();
    step();
    check("stats_exec1", bus.ExecCnt, 16'h1);
    check("stats_squash4", bus.SquashCnt, 16'h4);
    bus.RegW = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the multicycle control FSM. It consumes the FSM's raw write-enables: RegW, MemW, NextPC and BranchS.
- It holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field against them.
- It produces the gated RegWrite, MemWrite and PCWrite strobes that drive the register file, data memory and PC register.

Parameters:
- NV_EXECUTES, default 0, meaning: condition code 4'b1111 executes when 1 and never executes when 0.
- CNT_W, default 16, meaning: width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Cond  in  4  instruction condition field Instr[31:28]
- ALUFlags  in  4  ALU result flags, bit order {N,Z,C,V} = [3:0]
- FlagW  in  2  from the ALU decoder; [1] writes N,Z and [0] writes C,V
- Rd  in  4  destination register field
- RegW  in  1  raw register-write request from the FSM
- MemW  in  1  raw memory-write request from the FSM
- NextPC  in  1  unconditional PC update (Fetch)
- BranchS  in  1  branch request from the FSM
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated data-memory write enable
- PCWrite  out  1  PC register enable
- Flags  out  4  current NZCV register
- CondEx  out  1  registered condition result, cond_ex_q

Behaviour:
- Reset (reset=0, asynchronous): Flags=4'b0000, cond_ex_q=0. RegWrite, MemWrite and PCWrite follow the equations below, so with cond_ex_q=0 they equal NextPC only.
- Combinational cond_ex_c from Cond and the current Flags register:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 equals NV_EXECUTES
- cond_ex_q <= cond_ex_c on every rising clk edge. Effective latency is one cycle, so write-back and memory-write states use the condition evaluated in the preceding cycle.
- Flag register update on the rising edge:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & cond_ex_c.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & cond_ex_c.
  - Otherwise Flags hold.
  - The condition is evaluated on the pre-update flags. An instruction that sets flags sees the old flags for its own condition, and the new flags are visible from the next cycle.
- Output equations (combinational from registered state):
  - PCS = (RegW & (Rd==4'hF)) | BranchS.
  - RegWrite = RegW & cond_ex_q.
  - MemWrite = MemW & cond_ex_q.
  - PCWrite = NextPC | (PCS & cond_ex_q).
- Boundary conditions:
  - NextPC is never gated, so Fetch always advances the PC even when cond_ex_q=0.
  - When RegW and BranchS are asserted together, PCWrite asserts once; no double count is needed.
  - FlagW=2'b11 with cond_ex_c=0 leaves all four flags unchanged.
  - Reset asserted mid-instruction clears the flags and cond_ex_q immediately; all gated writes drop in the same cycle, before the clock.
  - Deasserting reset is synchronous to clk by system design; no internal synchroniser is provided.

Optional Feature:
- Macro: COND_LOGIC_STATS_EN.
- When defined, two extra outputs are added, ExecCnt[CNT_W-1:0] and SquashCnt[CNT_W-1:0], both reset to 0.
  - Each cycle with (RegW|MemW|BranchS) asserted: ExecCnt increments if cond_ex_q=1, else SquashCnt increments.
  - Both counters saturate at all-ones; they do not wrap.
- When undefined, the counters and ports are absent and there is no other behavioural difference.

Test Plan:
- Reset: drive reset=0 mid-cycle with RegW=1, Cond=1110 -> Flags=0000, CondEx=0 and RegWrite=0 immediately; after release, next edge gives CondEx=1.
- Flag set: Cond=1110, FlagW=11, ALUFlags=0100 for one edge -> Flags=0100; next cycle Cond=0000 (EQ) gives CondEx=1 one edge later and RegW=1 gives RegWrite=1.
- Squash: Flags=0100, Cond=0001 (NE), MemW=1 after one edge -> MemWrite=0 and PCWrite=NextPC only.
- Partial write: Flags=0000, FlagW=01, ALUFlags=1111, Cond=1110 -> Flags=0011; then FlagW=00 holds Flags=0011.
- Signed compares: Flags N=1,V=0,Z=0 -> LT(1011) yields CondEx=1 and GE(1010) yields CondEx=0; N=1,V=1,Z=0 -> GT(1100) yields CondEx=1 and LE(1101) yields CondEx=0.
- PC paths: Rd=F, RegW=1, cond_ex_q=1 -> PCWrite=1 and RegWrite=1; BranchS=1 with cond_ex_q=0 -> PCWrite=0; Cond=1111 with NV_EXECUTES=0 -> CondEx=0. With COND_LOGIC_STATS_EN, 3 squashed writes give SquashCnt=3.
